// File: rtl/reset_sequencer_pkg.sv
// Shared types for the FPGA-top reset controller: reset cause codes, sequencer
// states and a width helper for the internal counters.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        POWER_ON = 2'd0,
        PLL_LOSS = 2'd1,
        EXTERNAL = 2'd2,
        SOFTWARE = 2'd3
    } reset_cause_t;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } reset_seq_state_t;

    localparam int SYNC_STAGES = 3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Three-flop synchronizer for an asynchronous level; the chain resets to
// RESET_STATE so the synchronized side starts in a known (faulted) condition.
module reset_sequencer_sync
    import reset_sequencer_pkg::*;
#(
    parameter logic RESET_STATE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], async_i};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= {SYNC_STAGES{RESET_STATE}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// FPGA-top reset controller: qualifies synchronized reset sources for a hold
// time, then releases the downstream reset domains one after another.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 1024,
    parameter int STAGE_DELAY = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_locked_i,
    input  logic                  ext_reset_req_i,
    input  logic                  sw_reset_req_i,
    output logic [NUM_STAGES-1:0] stage_reset_o,
    output logic                  sequence_done_o,
    output logic [1:0]            reset_cause_o
);

    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int DW = cnt_width(STAGE_DELAY);
    localparam int SW = cnt_width(NUM_STAGES);

    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DELAY_LAST = DW'(STAGE_DELAY - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);

    logic pll_sync;
    logic ext_sync;
    logic clean;

    reset_sequencer_sync #(.RESET_STATE(1'b0)) u_pll_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (pll_locked_i),
        .sync_o  (pll_sync)
    );

    reset_sequencer_sync #(.RESET_STATE(1'b1)) u_ext_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (ext_reset_req_i),
        .sync_o  (ext_sync)
    );

    assign clean = pll_sync & ~ext_sync & ~sw_reset_req_i;

    reset_seq_state_t      state_q,       state_d;
    logic [HW-1:0]         hold_cnt_q,    hold_cnt_d;
    logic [DW-1:0]         delay_cnt_q,   delay_cnt_d;
    logic [SW-1:0]         stage_idx_q,   stage_idx_d;
    logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
    logic                  done_q,        done_d;
    reset_cause_t          cause_q,       cause_d;

    reset_cause_t          fault_cause;
    logic [SW-1:0]         idx_next;

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        delay_cnt_d   = delay_cnt_q;
        stage_idx_d   = stage_idx_q;
        stage_reset_d = stage_reset_q;
        done_d        = done_q;
        cause_d       = cause_q;
        idx_next      = stage_idx_q + 1'b1;

        // Priority when several sources fault on the same edge.
        fault_cause = SOFTWARE;
        if (!pll_sync) begin
            fault_cause = PLL_LOSS;
        end else if (ext_sync) begin
            fault_cause = EXTERNAL;
        end

        unique case (state_q)
            ASSERT: begin
                stage_reset_d = '1;
                done_d        = 1'b0;
                delay_cnt_d   = '0;
                stage_idx_d   = '0;
                if (!clean) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    if (NUM_STAGES == 1) begin
                        state_d       = RUN;
                        stage_reset_d = '0;
                        done_d        = 1'b1;
                    end else begin
                        state_d          = RELEASE;
                        stage_reset_d[0] = 1'b0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            RELEASE: begin
                if (!clean) begin
                    state_d       = ASSERT;
                    hold_cnt_d    = '0;
                    delay_cnt_d   = '0;
                    stage_idx_d   = '0;
                    stage_reset_d = '1;
                    done_d        = 1'b0;
                    cause_d       = fault_cause;
                end else if (delay_cnt_q == DELAY_LAST) begin
                    delay_cnt_d             = '0;
                    stage_idx_d             = idx_next;
                    stage_reset_d[idx_next] = 1'b0;
                    if (idx_next == STAGE_LAST) begin
                        state_d       = RUN;
                        stage_reset_d = '0;
                        done_d        = 1'b1;
                    end
                end else begin
                    delay_cnt_d = delay_cnt_q + 1'b1;
                end
            end

            RUN: begin
                stage_reset_d = '0;
                done_d        = 1'b1;
                if (!clean) begin
                    state_d       = ASSERT;
                    hold_cnt_d    = '0;
                    delay_cnt_d   = '0;
                    stage_idx_d   = '0;
                    stage_reset_d = '1;
                    done_d        = 1'b0;
                    cause_d       = fault_cause;
                end
            end

            default: begin
                state_d       = ASSERT;
                hold_cnt_d    = '0;
                delay_cnt_d   = '0;
                stage_idx_d   = '0;
                stage_reset_d = '1;
                done_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ASSERT;
            hold_cnt_q    <= '0;
            delay_cnt_q   <= '0;
            stage_idx_q   <= '0;
            stage_reset_q <= '1;
            done_q        <= 1'b0;
            cause_q       <= POWER_ON;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            delay_cnt_q   <= delay_cnt_d;
            stage_idx_q   <= stage_idx_d;
            stage_reset_q <= stage_reset_d;
            done_q        <= done_d;
            cause_q       <= cause_d;
        end
    end

    assign stage_reset_o   = stage_reset_q;
    assign sequence_done_o = done_q;
    assign reset_cause_o   = cause_q;

endmodule
